// File: rtl/apb_master_bridge.sv
// APB initiator: converts a valid/ready command port into APB SETUP/ACCESS
// transfers with a bounded pready wait, and edge-detects the peripheral interrupt.
module apb_master_bridge #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              intr,
  output logic              intr_rise
);

  // TIMEOUT=0 still needs a 1-bit counter so the declarations stay legal
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_intr_hist;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;

  assign w_cnt_inc = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == TO_VAL);
  assign cmd_ready = (r_state == S_IDLE) && !preset;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (cmd_valid) begin
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
            psel    <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable    <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : prdata;
            r_state   <= S_IDLE;
          end else begin
            r_wait_cnt <= w_cnt_inc;
            // abort: the peripheral never answered within the budget
            if (w_timeout) begin
              psel      <= 1'b0;
              penable   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_intr_hist <= 1'b0;
      intr_rise   <= 1'b0;
    end else begin
      r_intr_hist <= intr;
      intr_rise   <= intr && !r_intr_hist;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: write, wait-state read, timeout,
// back-to-back writes, reset mid-ACCESS and interrupt edge detection.
module tb_apb_master_bridge;
  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [1:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [1:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata = '0;
  logic       pready = 1'b0;
  logic       intr = 1'b0, intr_rise;

  int n_chk = 0, n_err = 0;

  apb_master_bridge #(.ADDR_W(2), .DATA_W(8), .TIMEOUT(4)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .intr(intr), .intr_rise(intr_rise)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Issue one command, then drive pready low for 'waits' ACCESS cycles.
  task automatic xfer(input logic wr, input logic [1:0] a, input logic [7:0] wd,
                      input int waits, input logic [7:0] rd,
                      output int lat, output int en_cyc, output logic rv,
                      output logic [7:0] rdat, output logic err,
                      output logic rdy_at_rsp, output logic bus_at_rsp,
                      output logic stable);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
    lat = 1; en_cyc = 0; rv = 1'b0; rdat = '0; err = 1'b0;
    rdy_at_rsp = 1'b0; bus_at_rsp = 1'b1; stable = 1'b1;
    for (int k = 0; k < 40 && !rv; k++) begin
      if (penable) begin
        en_cyc++;
        if (paddr !== a || pwdata !== wd || pwrite !== wr) stable = 1'b0;
        pready = (en_cyc > waits);
        prdata = rd;
      end else begin
        pready = 1'b0;
      end
      tick();
      lat++;
      if (rsp_valid) begin
        rv = 1'b1; rdat = rsp_rdata; err = rsp_err;
        rdy_at_rsp = cmd_ready; bus_at_rsp = psel | penable;
      end
    end
    pready = 1'b0; prdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, en;
    logic rv, err, rdy, bus, stb;
    logic [7:0] rdat;
    int acc_t[3], n_acc, gaps[4], n_gap, lowrun, rsp_cnt;
    logic seen_hi, accepted;
    logic [1:0] qa[3], sa[3];
    logic [7:0] qd[3];
    int ns, rise_cnt;
    logic [11:0] ipat, erise;

    // reset
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_outs", {14'd0, paddr, pwdata, rsp_rdata}, 0);
    chk("rst_bits", {29'd0, pwrite, rsp_err, intr_rise}, 0);
    preset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 1);

    // write, zero wait: check SETUP then ACCESS phases by hand
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd2; cmd_wdata = 8'hA5; pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("wr_setup", {30'd0, psel, penable}, 32'h2);
    chk("wr_setup_ready", 32'(cmd_ready), 0);
    tick();
    chk("wr_access", {30'd0, psel, penable}, 32'h3);
    chk("wr_access_bus", {21'd0, pwrite, paddr, pwdata}, {21'd0, 1'b1, 2'd2, 8'hA5});
    chk("wr_no_rsp_yet", 32'(rsp_valid), 0);
    tick();
    chk("wr_rsp", {29'd0, rsp_valid, rsp_err, psel}, 32'h4);
    chk("wr_rdata", 32'(rsp_rdata), 0);
    chk("wr_ready_at_rsp", 32'(cmd_ready), 1);
    pready = 1'b0;
    tick();
    chk("wr_rsp_pulse", 32'(rsp_valid), 0);

    // read, 2 wait states
    xfer(1'b0, 2'd1, 8'h5A, 2, 8'h3C, lat, en, rv, rdat, err, rdy, bus, stb);
    chk("rd_rsp_seen", 32'(rv), 1);
    chk("rd_latency", 32'(lat), 5);
    chk("rd_penable_cycles", 32'(en), 3);
    chk("rd_rdata", 32'(rdat), 32'h3C);
    chk("rd_err", 32'(err), 0);
    chk("rd_stable", 32'(stb), 1);
    tick();

    // timeout (TIMEOUT=4)
    xfer(1'b0, 2'd3, 8'h00, 100, 8'hEE, lat, en, rv, rdat, err, rdy, bus, stb);
    chk("to_rsp_seen", 32'(rv), 1);
    chk("to_penable_cycles", 32'(en), 4);
    chk("to_latency", 32'(lat), 6);
    chk("to_err", 32'(err), 1);
    chk("to_rdata", 32'(rdat), 0);
    chk("to_ready", 32'(rdy), 1);
    chk("to_bus_dropped", 32'(bus), 0);
    tick();

    // back-to-back writes with cmd_valid held high
    qa[0] = 2'd0; qa[1] = 2'd1; qa[2] = 2'd3;
    qd[0] = 8'h11; qd[1] = 8'h22; qd[2] = 8'h33;
    n_acc = 0; n_gap = 0; lowrun = 0; rsp_cnt = 0; seen_hi = 1'b0; ns = 0;
    pready = 1'b1; cmd_write = 1'b1; cmd_valid = 1'b1;
    cmd_addr = qa[0]; cmd_wdata = qd[0];
    for (int t = 0; t < 20; t++) begin
      accepted = cmd_valid && cmd_ready;
      tick();
      if (accepted) begin
        if (n_acc < 3) acc_t[n_acc] = t;
        n_acc++;
        if (n_acc < 3) begin cmd_addr = qa[n_acc]; cmd_wdata = qd[n_acc]; end
        else cmd_valid = 1'b0;
      end
      if (psel && !penable && ns < 3) begin sa[ns] = paddr; ns++; end
      if (psel) begin
        if (seen_hi && lowrun > 0 && n_gap < 4) begin gaps[n_gap] = lowrun; n_gap++; end
        seen_hi = 1'b1; lowrun = 0;
      end else if (seen_hi) lowrun++;
      if (rsp_valid) rsp_cnt++;
    end
    pready = 1'b0; cmd_valid = 1'b0;
    chk("b2b_accepts", 32'(n_acc), 3);
    chk("b2b_rsp_count", 32'(rsp_cnt), 3);
    chk("b2b_gap_count", 32'(n_gap), 2);
    if (n_acc == 3) begin
      chk("b2b_spacing0", 32'(acc_t[1] - acc_t[0]), 3);
      chk("b2b_spacing1", 32'(acc_t[2] - acc_t[1]), 3);
    end
    if (n_gap == 2) begin
      chk("b2b_gap0", 32'(gaps[0]), 1);
      chk("b2b_gap1", 32'(gaps[1]), 1);
    end
    if (ns == 3) chk("b2b_addrs", {26'd0, sa[0], sa[1], sa[2]}, {26'd0, 2'd0, 2'd1, 2'd3});
    chk("b2b_last_wdata", 32'(pwdata), 32'h33);

    // reset mid-ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid_in_access", {30'd0, psel, penable}, 32'h3);
    preset = 1'b1;
    tick();
    chk("mid_bus_dropped", {30'd0, psel, penable}, 0);
    chk("mid_no_rsp", 32'(rsp_valid), 0);
    chk("mid_ready_in_rst", 32'(cmd_ready), 0);
    preset = 1'b0;
    #1;
    chk("mid_ready_after", 32'(cmd_ready), 1);
    rsp_cnt = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (rsp_valid || psel) rsp_cnt++;
    end
    chk("mid_quiet", 32'(rsp_cnt), 0);

    // interrupt: 1 x5, 0, 1 x2, then 0
    ipat  = 12'h0DF;
    erise = 12'h041;
    rise_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      intr = ipat[i];
      tick();
      chk($sformatf("intr_rise_%0d", i), 32'(intr_rise), 32'(erise[i]));
      if (intr_rise) rise_cnt++;
    end
    chk("intr_pulse_count", 32'(rise_cnt), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
